// File: rtl/binary_to_bcd.sv
// Free-running sequential double-dabble converter: samples bnum, shifts it
// through a BCD register over IN_WIDTH cycles, then publishes the low three digits.
module binary_to_bcd #(
  parameter int IN_WIDTH   = 33,
  parameter int BCD_DIGITS = 10
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [IN_WIDTH-1:0] bnum,
  output logic [3:0]          hundreds,
  output logic [3:0]          tens,
  output logic [3:0]          ones,
  output logic                overflow,
  output logic                done
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam int BCD_W = 4 * BCD_DIGITS;
  localparam int CNT_W = $clog2(IN_WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(IN_WIDTH - 1);

  logic [1:0]                  state_reg;
  logic [1:0]                  state_next;
  logic [IN_WIDTH-1:0]         bin_reg;
  logic [BCD_W-1:0]            bcd_reg;
  logic [CNT_W-1:0]            count_reg;
  logic [BCD_W-1:0]            bcd_adj;
  logic [BCD_W+IN_WIDTH-1:0]   shift_next;

  // Digits 0..4 pass through; 5..9 get +3 so the following shift carries into the next digit.
  genvar gi;
  generate
    for (gi = 0; gi < BCD_DIGITS; gi++) begin : g_adj
      assign bcd_adj[gi*4 +: 4] = (bcd_reg[gi*4 +: 4] >= 4'd5) ?
                                  bcd_reg[gi*4 +: 4] + 4'd3 : bcd_reg[gi*4 +: 4];
    end
  endgenerate

  assign shift_next = {bcd_adj, bin_reg} << 1;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    state_next = SHIFT;
      SHIFT:   if (count_reg == LAST_SHIFT) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      bin_reg   <= '0;
      bcd_reg   <= '0;
      count_reg <= '0;
      hundreds  <= 4'd0;
      tens      <= 4'd0;
      ones      <= 4'd0;
      overflow  <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_reg <= state_next;
      done      <= 1'b0;
      case (state_reg)
        IDLE: begin
          bin_reg   <= bnum;
          bcd_reg   <= '0;
          count_reg <= '0;
        end
        SHIFT: begin
          bcd_reg   <= shift_next[BCD_W+IN_WIDTH-1:IN_WIDTH];
          bin_reg   <= shift_next[IN_WIDTH-1:0];
          count_reg <= count_reg + CNT_W'(1);
        end
        DONE: begin
          ones     <= bcd_reg[3:0];
          tens     <= bcd_reg[7:4];
          hundreds <= bcd_reg[11:8];
          // Anything in the thousands digit or above means the value is >= 1000.
          overflow <= |bcd_reg[BCD_W-1:12];
          done     <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_binary_to_bcd.sv
// Bench for binary_to_bcd: table vectors, random values and reset/latency
// corner cases, with expected digits queued at drive time and popped on done.
module tb_binary_to_bcd;

  typedef struct {
    logic [32:0] v;
    logic [3:0]  h;
    logic [3:0]  t;
    logic [3:0]  o;
    logic        ovf;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic [32:0] bnum;
  logic [3:0]  hundreds;
  logic [3:0]  tens;
  logic [3:0]  ones;
  logic        overflow;
  logic        done;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int txn         = 0;
  vec_t sb[$];

  binary_to_bcd dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bnum     (bnum),
    .hundreds (hundreds),
    .tens     (tens),
    .ones     (ones),
    .overflow (overflow),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, got, got, exp, exp);
    end
  endtask

  function automatic vec_t model(input logic [32:0] v);
    vec_t r;
    logic [32:0] m;
    m     = v % 33'd1000;
    r.v   = v;
    r.h   = 4'(m / 33'd100);
    r.t   = 4'((m / 33'd10) % 33'd10);
    r.o   = 4'(m % 33'd10);
    r.ovf = (v >= 33'd1000);
    return r;
  endfunction

  // Scoreboard monitor: one pop per done pulse, plus digit-range, pulse-width and period checks.
  initial begin
    int   last_done = -1;
    logic prev_done = 1'b0;
    vec_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        last_done = -1;
        prev_done = 1'b0;
      end else begin
        if (hundreds > 4'd9 || tens > 4'd9 || ones > 4'd9) begin
          miscompares++;
          $display("FAIL digit_range: got %0d/%0d/%0d, required each <= 9", hundreds, tens, ones);
        end
        if (done && prev_done) begin
          miscompares++;
          $display("FAIL done_width: done high on two consecutive cycles, required one");
        end
        if (done) begin
          if (last_done >= 0) check("done_period", 64'(cyc - last_done), 64'd35);
          last_done = cyc;
          if (sb.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_done: done pulse with empty scoreboard");
          end else begin
            e = sb.pop_front();
            txn++;
            $display("txn %0d: bnum=%0d -> %0d%0d%0d ovf=%0b (exp %0d%0d%0d ovf=%0b)",
                     txn, e.v, hundreds, tens, ones, overflow, e.h, e.t, e.o, e.ovf);
            check("digits", {51'd0, hundreds, tens, ones, overflow},
                  {51'd0, e.h, e.t, e.o, e.ovf});
          end
        end
        prev_done = done;
      end
    end
  end

  task automatic wait_done();
    bit seen = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1;
        break;
      end
    end
    if (!seen) begin
      miscompares++;
      $display("FAIL done_timeout: no done pulse within 200 cycles");
    end
  endtask

  // Called at the negedge right after a done pulse: the next posedge is the IDLE sample.
  task automatic apply(input vec_t e);
    bnum = e.v;
    sb.push_back(e);
    wait_done();
  endtask

  initial begin
    vec_t tbl[8];
    vec_t e;
    int   n;
    bit   seen;

    tbl[0] = '{33'd43,         4'd0, 4'd4, 4'd3, 1'b0};
    tbl[1] = '{33'd21,         4'd0, 4'd2, 4'd1, 1'b0};
    tbl[2] = '{33'd30,         4'd0, 4'd3, 4'd0, 1'b0};
    tbl[3] = '{33'd0,          4'd0, 4'd0, 4'd0, 1'b0};
    tbl[4] = '{33'd999,        4'd9, 4'd9, 4'd9, 1'b0};
    tbl[5] = '{33'd1000,       4'd0, 4'd0, 4'd0, 1'b1};
    tbl[6] = '{33'd1234,       4'd2, 4'd3, 4'd4, 1'b1};
    tbl[7] = '{33'd8589934591, 4'd5, 4'd9, 4'd1, 1'b1};

    // Reset state with a nonzero input present.
    rst_n = 1'b0;
    bnum  = 33'd43;
    repeat (4) @(negedge clk);
    check("reset_digits", {52'd0, hundreds, tens, ones}, 64'd0);
    check("reset_ovf_done", {62'd0, overflow, done}, 64'd0);

    // Latency: first done pulse 35 edges after release.
    rst_n = 1'b1;
    sb.push_back(tbl[0]);
    n = 0;
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (done) begin
        seen = 1;
        break;
      end
    end
    if (!seen) begin
      miscompares++;
      $display("FAIL first_done_timeout: no done within 100 edges of reset release");
    end else begin
      check("first_latency", 64'(n), 64'd35);
    end

    for (int i = 1; i < 8; i++) apply(tbl[i]);

    // Input change during SHIFT is ignored until the next IDLE sample.
    bnum = tbl[0].v;
    sb.push_back(tbl[0]);
    repeat (10) @(negedge clk);
    bnum = tbl[1].v;
    wait_done();
    sb.push_back(tbl[1]);
    wait_done();

    // Asynchronous reset mid-SHIFT clears outputs without waiting for a clock edge.
    bnum = 33'd999;
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_digits", {52'd0, hundreds, tens, ones}, 64'd0);
    check("async_reset_ovf_done", {62'd0, overflow, done}, 64'd0);
    sb.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    sb.push_back(tbl[6]);
    bnum = tbl[6].v;
    wait_done();

    for (int i = 0; i < 1000; i++) begin
      logic [32:0] v;
      v = {1'($urandom_range(1, 0)), 32'($urandom())};
      if (i % 4 == 1) v = 33'($urandom_range(2000, 0));
      e = model(v);
      apply(e);
    end

    repeat (2) @(negedge clk);
    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
